// File: rtl/writeback_unit.sv
// writeback_unit
//   Write-back stage and owner of the architectural register file.
//   Takes results from execute over a valid/ready handshake. Each instruction
//   can commit up to two destinations, with one register write per cycle.
//   Tracks registers that have writes in flight (busy mask) for issue stalls.
//   Reports each retirement with its RIP and a wrapping 32-bit counter.
// Ports
//   clk, reset                    : rising-edge clock, async active-low reset
//   wbValidIn / wbReadyOut        : execute handshake (ready only in IDLE)
//   destReg*/result*              : primary destination and value
//   destRegisterSpecial*/resultSpecialIn : secondary destination and value
//   currentRipIn                  : RIP of the incoming instruction
//   claimValidIn / claimRegIn     : read stage marks a register busy
//   registerFileOut, busyMaskOut  : registered architectural state, busy bits
//   retireValidOut/retiredRipOut/retireCountOut : retirement report
module writeback_unit #(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 64,
   parameter int RIP_W    = 64
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 wbValidIn,
   output logic                                 wbReadyOut,
   input  logic [$clog2(NUM_REGS)-1:0]          destRegIn,
   input  logic                                 destRegValidIn,
   input  logic [DATA_W-1:0]                    resultIn,
   input  logic [$clog2(NUM_REGS)-1:0]          destRegisterSpecialIn,
   input  logic                                 destRegisterSpecialValidIn,
   input  logic [DATA_W-1:0]                    resultSpecialIn,
   input  logic [RIP_W-1:0]                     currentRipIn,
   input  logic                                 claimValidIn,
   input  logic [$clog2(NUM_REGS)-1:0]          claimRegIn,
   output logic [NUM_REGS-1:0][DATA_W-1:0]      registerFileOut,
   output logic [NUM_REGS-1:0]                  busyMaskOut,
   output logic                                 retireValidOut,
   output logic [RIP_W-1:0]                     retiredRipOut,
   output logic [31:0]                          retireCountOut
);
   localparam int IDX_W = $clog2(NUM_REGS);

   localparam logic [0:0] S_IDLE       = 1'b0;
   localparam logic [0:0] S_WR_SPECIAL = 1'b1;

   logic [0:0]                      r_state;
   logic [0:0]                      w_state_nxt;
   logic [NUM_REGS-1:0][DATA_W-1:0] r_rf;
   logic [NUM_REGS-1:0]             r_busy;
   logic [NUM_REGS-1:0]             w_busy_nxt;
   logic [IDX_W-1:0]                r_hold_idx;
   logic [DATA_W-1:0]               r_hold_data;
   logic [RIP_W-1:0]                r_hold_rip;
   logic                            r_retire_vld;
   logic [RIP_W-1:0]                r_retire_rip;
   logic [31:0]                     r_retire_cnt;

   logic                            w_xfer;
   logic                            w_split;
   logic                            w_hold_load;
   logic                            w_wr_en;
   logic [IDX_W-1:0]                w_wr_idx;
   logic [DATA_W-1:0]               w_wr_data;
   logic                            w_retire;
   logic [RIP_W-1:0]                w_retire_rip;

   assign wbReadyOut = (r_state == S_IDLE);
   assign w_xfer     = wbValidIn && wbReadyOut;
   // Two distinct destinations need a second write cycle; same-reg pairs
   // collapse into one write where the secondary value wins.
   assign w_split    = destRegValidIn && destRegisterSpecialValidIn &&
                       (destRegIn != destRegisterSpecialIn);

   always_comb begin
      w_state_nxt  = r_state;
      w_hold_load  = 1'b0;
      w_wr_en      = 1'b0;
      w_wr_idx     = '0;
      w_wr_data    = '0;
      w_retire     = 1'b0;
      w_retire_rip = r_hold_rip;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_retire_rip = currentRipIn;
               if (w_split) begin
                  w_wr_en     = 1'b1;
                  w_wr_idx    = destRegIn;
                  w_wr_data   = resultIn;
                  w_hold_load = 1'b1;
                  w_state_nxt = S_WR_SPECIAL;
               end else begin
                  w_retire = 1'b1;
                  if (destRegisterSpecialValidIn) begin
                     w_wr_en   = 1'b1;
                     w_wr_idx  = destRegisterSpecialIn;
                     w_wr_data = resultSpecialIn;
                  end else if (destRegValidIn) begin
                     w_wr_en   = 1'b1;
                     w_wr_idx  = destRegIn;
                     w_wr_data = resultIn;
                  end
               end
            end
         end
         S_WR_SPECIAL: begin
            w_wr_en     = 1'b1;
            w_wr_idx    = r_hold_idx;
            w_wr_data   = r_hold_data;
            w_retire    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A claim landing on the same edge as a write to that register wins:
   // the claim belongs to a younger instruction.
   always_comb begin
      w_busy_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_busy_nxt[i] = (r_busy[i] & ~(w_wr_en && (w_wr_idx == IDX_W'(i)))) |
                         (claimValidIn && (claimRegIn == IDX_W'(i)));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_rf         <= '0;
         r_busy       <= '0;
         r_hold_idx   <= '0;
         r_hold_data  <= '0;
         r_hold_rip   <= '0;
         r_retire_vld <= 1'b0;
         r_retire_rip <= '0;
         r_retire_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= w_busy_nxt;
         r_retire_vld <= w_retire;
         if (w_wr_en)
            r_rf[w_wr_idx] <= w_wr_data;
         if (w_hold_load) begin
            r_hold_idx  <= destRegisterSpecialIn;
            r_hold_data <= resultSpecialIn;
            r_hold_rip  <= currentRipIn;
         end
         if (w_retire) begin
            r_retire_rip <= w_retire_rip;
            r_retire_cnt <= r_retire_cnt + 32'd1;
         end
      end
   end

   assign registerFileOut = r_rf;
   assign busyMaskOut     = r_busy;
   assign retireValidOut  = r_retire_vld;
   assign retiredRipOut   = r_retire_rip;
   assign retireCountOut  = r_retire_cnt;
endmodule
